// File: rtl/mul_share_arbiter_if.sv
// Requester handshake, multiplier datapath hookup and response bus for mul_share_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface mul_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = 2
);
  logic                   en;
  logic [NUM_REQ-1:0]     req_valid;
  logic [4*NUM_REQ-1:0]   req_a;
  logic [4*NUM_REQ-1:0]   req_b;
  logic [NUM_REQ-1:0]     req_ready;
  logic [3:0]             mul_a;
  logic [3:0]             mul_b;
  logic [7:0]             mul_q;
  logic [NUM_REQ-1:0]     resp_valid;
  logic [IDW-1:0]         resp_id;
  logic [7:0]             resp_q;
  logic [3:0]             in_flight;

  modport slave (
    input  en, req_valid, req_a, req_b, mul_q,
    output req_ready, mul_a, mul_b, resp_valid, resp_id, resp_q, in_flight
  );

  modport master (
    output en, req_valid, req_a, req_b, mul_q,
    input  req_ready, mul_a, mul_b, resp_valid, resp_id, resp_q, in_flight
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one external pipelined 4x4 multiplier; a tag shift register
// matched to the multiplier depth routes each product back to the requester that issued it.
module mul_share_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned PIPELINE_DEPTH = 3,
  parameter int unsigned IDW            = 2
) (
  input logic                clk,
  input logic                rst_n,
  mul_share_arbiter_if.slave bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("mul_share_arbiter: NUM_REQ must be 2..8");
  end
  if (PIPELINE_DEPTH > 8) begin : g_bad_depth
    $error("mul_share_arbiter: PIPELINE_DEPTH must be 0..8");
  end
  if (IDW != $clog2(NUM_REQ)) begin : g_bad_idw
    $error("mul_share_arbiter: IDW must equal clog2(NUM_REQ)");
  end

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     cand;
  logic               hs;
  logic [NUM_REQ-1:0] ready;
  logic [3:0]         sel_a, sel_b;
  logic [3:0]         mul_a_q, mul_b_q;
  logic [3:0]         in_flight_q;

  // Stage k holds the tag of the operation whose product is k multiplier stages deep.
  logic [PIPELINE_DEPTH:0] tag_vld_q;
  logic [IDW-1:0]          tag_id_q [PIPELINE_DEPTH+1];

  logic               resp_vld;
  logic [IDW-1:0]     resp_idx;
  logic [NUM_REQ-1:0] resp_vec;

  // First valid requester at or after ptr, searching cyclically.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDW'((32'(ptr_q) + off) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // rst_n gates ready so no handshake can complete while reset is held.
  assign hs = bus.en & rst_n & grant_found;

  always_comb begin
    ready = '0;
    if (hs) begin
      ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = bus.req_a[4*i +: 4];
        sel_b = bus.req_b[4*i +: 4];
      end
    end
  end

  assign ptr_d = hs ? IDW'((32'(grant_idx) + 32'd1) % NUM_REQ) : ptr_q;

  assign resp_vld = tag_vld_q[PIPELINE_DEPTH];
  assign resp_idx = tag_id_q[PIPELINE_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
      in_flight_q <= '0;
      for (int k = 0; k <= int'(PIPELINE_DEPTH); k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      if (hs) begin
        mul_a_q <= sel_a;
        mul_b_q <= sel_b;
      end
      tag_vld_q[0] <= hs;
      tag_id_q[0]  <= hs ? grant_idx : '0;
      for (int k = 1; k <= int'(PIPELINE_DEPTH); k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
      case ({hs, resp_vld})
        2'b10:   in_flight_q <= in_flight_q + 4'd1;
        2'b01:   in_flight_q <= in_flight_q - 4'd1;
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  always_comb begin
    resp_vec = '0;
    if (resp_vld) begin
      resp_vec[resp_idx] = 1'b1;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.resp_valid = resp_vec;
  assign bus.resp_id    = resp_vld ? resp_idx : '0;
  assign bus.resp_q     = resp_vld ? bus.mul_q : 8'd0;
  assign bus.in_flight  = in_flight_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a 3-stage multiplier model attached;
// grants and responses are logged at negedge and compared with hand-computed values.
module tb_mul_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int g_vec[$];
  int g_cyc[$];
  int r_vec[$];
  int r_id[$];
  int r_q[$];
  int r_cyc[$];

  logic [7:0] mpipe [3];

  mul_share_arbiter_if #(.NUM_REQ(4), .IDW(2)) bus ();

  mul_share_arbiter #(
    .NUM_REQ        (4),
    .PIPELINE_DEPTH (3),
    .IDW            (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Three-stage external multiplier; no reset, so stale products survive a reset.
  always @(posedge clk) begin
    mpipe[0] <= bus.mul_a * bus.mul_b;
    mpipe[1] <= mpipe[0];
    mpipe[2] <= mpipe[1];
  end
  assign bus.mul_q = mpipe[2];

  always @(negedge clk) begin
    if (bus.req_ready != '0) begin
      g_vec.push_back(int'(bus.req_ready));
      g_cyc.push_back(cyc);
    end
    if (bus.resp_valid != '0) begin
      r_vec.push_back(int'(bus.resp_valid));
      r_id.push_back(int'(bus.resp_id));
      r_q.push_back(int'(bus.resp_q));
      r_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    g_vec.delete(); g_cyc.delete();
    r_vec.delete(); r_id.delete(); r_q.delete(); r_cyc.delete();
  endtask

  // Compare logged responses k against expected id/product, issued by grant k.
  task automatic chk_resp(input string tag, input int k, input int id, input int q);
    if (k < r_id.size() && k < g_cyc.size()) begin
      chk($sformatf("%s_id%0d", tag, k), r_id[k], id);
      chk($sformatf("%s_vec%0d", tag, k), r_vec[k], 1 << id);
      chk($sformatf("%s_q%0d", tag, k), r_q[k], q);
      chk($sformatf("%s_lat%0d", tag, k), r_cyc[k], g_cyc[k] + 4);
    end
  endtask

  initial begin
    int exp_grant[4];
    int exp_q[4];

    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    tick();
    tick();

    // Reset state; ready must stay low while reset is held even with requests pending.
    bus.en        = 1'b1;
    bus.req_valid = 4'hF;
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_in_flight", bus.in_flight, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    bus.req_valid = '0;
    rst_n         = 1'b1;
    tick();

    // Single op: requester 2, 9*7.
    bus.req_valid = 4'b0100;
    bus.req_a     = 16'h0900;
    bus.req_b     = 16'h0700;
    #1;
    chk("single_ready", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid = '0;
    chk("single_mul_a", bus.mul_a, 9);
    chk("single_mul_b", bus.mul_b, 7);
    chk("single_if_e0", bus.in_flight, 1);
    tick();
    chk("single_if_e1", bus.in_flight, 1);
    chk("single_noresp_e1", bus.resp_valid, 0);
    tick();
    chk("single_if_e2", bus.in_flight, 1);
    chk("single_noresp_e2", bus.resp_valid, 0);
    tick();
    chk("single_resp_valid", bus.resp_valid, 4'b0100);
    chk("single_resp_id", bus.resp_id, 2);
    chk("single_resp_q", bus.resp_q, 63);
    chk("single_if_e3", bus.in_flight, 1);
    tick();
    chk("single_resp_done", bus.resp_valid, 0);
    chk("single_id_idle", bus.resp_id, 0);
    chk("single_if_e4", bus.in_flight, 0);

    // Boundary 15*15 on requester 3 (ptr is 3 here, moves to 0).
    bus.req_valid = 4'b1000;
    bus.req_a     = 16'hF000;
    bus.req_b     = 16'hF000;
    #1;
    chk("max_ready", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = '0;
    tick(); tick(); tick();
    chk("max_resp_valid", bus.resp_valid, 4'b1000);
    chk("max_resp_id", bus.resp_id, 3);
    chk("max_resp_q", bus.resp_q, 225);
    tick();

    // Contention: all valid, a=i+1, b=15, from ptr 0.
    clear_logs();
    bus.req_valid = 4'hF;
    bus.req_a     = 16'h4321;
    bus.req_b     = 16'hFFFF;
    exp_grant     = '{1, 2, 4, 8};
    exp_q         = '{15, 30, 45, 60};
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ctn_ready%0d", k), bus.req_ready, exp_grant[k]);
      tick();
    end
    bus.req_valid = '0;
    chk("ctn_in_flight_peak", bus.in_flight, 4);
    repeat (4) tick();
    chk("ctn_n_grant", g_vec.size(), 4);
    chk("ctn_n_resp", r_id.size(), 4);
    for (int k = 0; k < 4; k++) chk_resp("ctn", k, k, exp_q[k]);
    chk("ctn_drained", bus.in_flight, 0);

    // Boundary a=0 on requester 0 (ptr 0 -> 1).
    bus.req_valid = 4'b0001;
    bus.req_a     = 16'h0000;
    bus.req_b     = 16'h000F;
    #1;
    chk("zero_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    tick(); tick(); tick();
    chk("zero_resp_valid", bus.resp_valid, 4'b0001);
    chk("zero_resp_q", bus.resp_q, 0);
    tick();

    // Fairness skip from ptr 1 with only 0 and 3 valid: 3, 0, 3.
    clear_logs();
    bus.req_valid = 4'b1001;
    bus.req_a     = 16'h2005;
    bus.req_b     = 16'h3003;
    #1;
    chk("fair_ready0", bus.req_ready, 4'b1000);
    tick();
    chk("fair_ready1", bus.req_ready, 4'b0001);
    tick();
    chk("fair_ready2", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = '0;
    repeat (4) tick();
    chk("fair_n_resp", r_id.size(), 3);
    chk_resp("fair", 0, 3, 6);
    chk_resp("fair", 1, 0, 15);
    chk_resp("fair", 2, 3, 6);
    chk("fair_drained", bus.in_flight, 0);

    // Enable low for 2 cycles in a stream from ptr 0.
    clear_logs();
    bus.req_valid = 4'hF;
    bus.req_a     = 16'h4321;
    bus.req_b     = 16'h1111;
    #1;
    chk("en_ready0", bus.req_ready, 4'b0001);
    tick();
    chk("en_ready1", bus.req_ready, 4'b0010);
    tick();
    bus.en = 1'b0;
    #1;
    chk("en_off_ready0", bus.req_ready, 0);
    chk("en_off_in_flight", bus.in_flight, 2);
    tick();
    chk("en_off_ready1", bus.req_ready, 0);
    tick();
    bus.req_valid = '0;
    tick(); tick();
    chk("en_n_grant", g_vec.size(), 2);
    chk("en_n_resp", r_id.size(), 2);
    chk_resp("en", 0, 0, 1);
    chk_resp("en", 1, 1, 2);
    chk("en_drained", bus.in_flight, 0);

    // Reset mid-flight: three issues (ptr 2 -> grants 2, 3, 0), reset a cycle later.
    bus.en        = 1'b1;
    bus.req_valid = 4'hF;
    bus.req_a     = 16'h5555;
    bus.req_b     = 16'h2222;
    tick(); tick(); tick();
    bus.req_valid = '0;
    tick();
    rst_n = 1'b0;
    clear_logs();
    #1;
    chk("mid_rst_in_flight", bus.in_flight, 0);
    chk("mid_rst_resp", bus.resp_valid, 0);
    chk("mid_rst_mul_a", bus.mul_a, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("mid_rst_no_resp", r_id.size(), 0);
    chk("mid_rst_if_after", bus.in_flight, 0);

    // New op after reset: ptr back to 0, requester 1 wins, 12*13.
    clear_logs();
    bus.req_valid = 4'b0010;
    bus.req_a     = 16'h00C0;
    bus.req_b     = 16'h00D0;
    #1;
    chk("post_rst_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    tick(); tick();
    chk("post_rst_early", bus.resp_valid, 0);
    tick();
    chk("post_rst_resp_valid", bus.resp_valid, 4'b0010);
    chk("post_rst_resp_id", bus.resp_id, 1);
    chk("post_rst_resp_q", bus.resp_q, 156);
    tick();
    chk("post_rst_n_resp", r_id.size(), 1);
    chk("post_rst_drained", bus.in_flight, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
